// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing one video RAM between the tile fetcher and two CPUs.
// Slots follow the 6 MHz pixel strobe; even slots go to video during active display.
//
// Ports:
//   CLK_48M, nVRESETH             clock, async active-low reset
//   pix_ce, hphase                pixel strobe and slot number {4H,2H,1H}
//   nHBLANK, nVBLANK              blanking (used only with VRAM_ARB_BLANK_CPU_EN)
//   vid_req/addr/valid/rdata      tile fetch port
//   cpuN_req/we/addr/wdata        CPU request ports, N=0,1
//   cpuN_ack/rdata                CPU completion and read data
//   ram_cs/we/addr/wdata/rdata    shared RAM port
//
// Option macro: VRAM_ARB_BLANK_CPU_EN -- CPUs own every slot during blanking.
module vram_slot_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int RD_TAP = 6
) (
    input  logic              CLK_48M,
    input  logic              nVRESETH,
    input  logic              pix_ce,
    input  logic [2:0]        hphase,
    input  logic              nHBLANK,
    input  logic              nVBLANK,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu0_req,
    input  logic              cpu0_we,
    input  logic [ADDR_W-1:0] cpu0_addr,
    input  logic [DATA_W-1:0] cpu0_wdata,
    output logic              cpu0_ack,
    output logic [DATA_W-1:0] cpu0_rdata,
    input  logic              cpu1_req,
    input  logic              cpu1_we,
    input  logic [ADDR_W-1:0] cpu1_addr,
    input  logic [DATA_W-1:0] cpu1_wdata,
    output logic              cpu1_ack,
    output logic [DATA_W-1:0] cpu1_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, VID, CPU0, CPU1} own_t;

    localparam logic [2:0] TAP = 3'(RD_TAP);

    own_t       owner;
    own_t       own_nxt;
    logic [2:0] sub;
    logic [2:0] sub_nxt;
    logic       rr;
    logic       rr_use;
    logic       slot_we;
    logic       blank;

`ifdef VRAM_ARB_BLANK_CPU_EN
    assign blank = ~(nHBLANK & nVBLANK);
`else
    logic unused_blank;
    assign blank        = 1'b0;
    assign unused_blank = nHBLANK ^ nVBLANK;
`endif

    // Sub-cycle saturates so a missing pix_ce holds the slot without a second ack.
    assign sub_nxt = pix_ce ? 3'd0 : ((sub == 3'd7) ? 3'd7 : sub + 3'd1);

    always_comb begin
        own_nxt = IDLE;
        rr_use  = 1'b0;
        if (blank) begin
            rr_use = 1'b1;
        end else if (!hphase[0]) begin
            if (vid_req) own_nxt = VID;
            else         rr_use  = 1'b1;
        end else if (!hphase[1]) begin
            own_nxt = cpu0_req ? CPU0 : (cpu1_req ? CPU1 : IDLE);
        end else begin
            own_nxt = cpu1_req ? CPU1 : (cpu0_req ? CPU0 : IDLE);
        end
        if (rr_use) begin
            if (!rr) own_nxt = cpu0_req ? CPU0 : (cpu1_req ? CPU1 : IDLE);
            else     own_nxt = cpu1_req ? CPU1 : (cpu0_req ? CPU0 : IDLE);
        end
    end

    always_ff @(posedge CLK_48M or negedge nVRESETH) begin
        if (!nVRESETH) begin
            owner      <= IDLE;
            sub        <= 3'd0;
            rr         <= 1'b0;
            slot_we    <= 1'b0;
            vid_valid  <= 1'b0;
            vid_rdata  <= '0;
            cpu0_ack   <= 1'b0;
            cpu0_rdata <= '0;
            cpu1_ack   <= 1'b0;
            cpu1_rdata <= '0;
            ram_cs     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            sub       <= sub_nxt;
            vid_valid <= 1'b0;
            cpu0_ack  <= 1'b0;
            cpu1_ack  <= 1'b0;
            if (pix_ce) begin
                owner  <= own_nxt;
                ram_cs <= (own_nxt != IDLE);
                ram_we <= 1'b0;
                // Pointer moves away from whichever CPU won a shared slot.
                if (rr_use && own_nxt == CPU0) rr <= 1'b1;
                if (rr_use && own_nxt == CPU1) rr <= 1'b0;
                unique case (own_nxt)
                    VID: begin
                        ram_addr  <= vid_addr;
                        ram_wdata <= '0;
                        slot_we   <= 1'b0;
                    end
                    CPU0: begin
                        ram_addr  <= cpu0_addr;
                        ram_wdata <= cpu0_wdata;
                        slot_we   <= cpu0_we;
                    end
                    CPU1: begin
                        ram_addr  <= cpu1_addr;
                        ram_wdata <= cpu1_wdata;
                        slot_we   <= cpu1_we;
                    end
                    IDLE: begin
                        slot_we <= 1'b0;
                    end
                endcase
            end else begin
                // Strobe sits inside the slot so address/data are settled on both edges.
                ram_we <= slot_we && (sub_nxt >= 3'd2) && (sub_nxt <= 3'd5);
                if (sub_nxt == TAP) begin
                    unique case (owner)
                        VID: begin
                            vid_valid <= 1'b1;
                            vid_rdata <= ram_rdata;
                        end
                        CPU0: begin
                            cpu0_ack   <= 1'b1;
                            cpu0_rdata <= ram_rdata;
                        end
                        CPU1: begin
                            cpu1_ack   <= 1'b1;
                            cpu1_rdata <= ram_rdata;
                        end
                        IDLE: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed testbench for vram_slot_arbiter.
// Bench drives the pixel strobe/slot counter and models the RAM and CPUs.
module tb_vram_slot_arbiter;

    logic        CLK_48M = 1'b0;
    logic        nVRESETH;
    logic        pix_ce;
    logic [2:0]  hphase;
    logic        nHBLANK;
    logic        nVBLANK;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic        vid_valid;
    logic [7:0]  vid_rdata;
    logic        cpu0_req;
    logic        cpu0_we;
    logic [12:0] cpu0_addr;
    logic [7:0]  cpu0_wdata;
    logic        cpu0_ack;
    logic [7:0]  cpu0_rdata;
    logic        cpu1_req;
    logic        cpu1_we;
    logic [12:0] cpu1_addr;
    logic [7:0]  cpu1_wdata;
    logic        cpu1_ack;
    logic [7:0]  cpu1_rdata;
    logic        ram_cs;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:8191];

    int total = 0;
    int bad   = 0;

    logic [2:0]  pcnt;
    logic [2:0]  cur_slot;
    logic [2:0]  sub_m;
    logic        stream0;
    logic        stream1;
    int          ack0_cnt, ack1_cnt, vv_cnt, cs_cnt;
    int          ack0_slot, ack0_sub, ack1_slot, ack1_sub;
    logic [7:0]  ack0_data, ack1_data;

    always #5 CLK_48M = ~CLK_48M;

    assign ram_rdata = mem[ram_addr];

    always @(posedge CLK_48M) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    vram_slot_arbiter dut (
        .CLK_48M    (CLK_48M),
        .nVRESETH   (nVRESETH),
        .pix_ce     (pix_ce),
        .hphase     (hphase),
        .nHBLANK    (nHBLANK),
        .nVBLANK    (nVBLANK),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_valid  (vid_valid),
        .vid_rdata  (vid_rdata),
        .cpu0_req   (cpu0_req),
        .cpu0_we    (cpu0_we),
        .cpu0_addr  (cpu0_addr),
        .cpu0_wdata (cpu0_wdata),
        .cpu0_ack   (cpu0_ack),
        .cpu0_rdata (cpu0_rdata),
        .cpu1_req   (cpu1_req),
        .cpu1_we    (cpu1_we),
        .cpu1_addr  (cpu1_addr),
        .cpu1_wdata (cpu1_wdata),
        .cpu1_ack   (cpu1_ack),
        .cpu1_rdata (cpu1_rdata),
        .ram_cs     (ram_cs),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: advance the timing model, then act as the CPUs/monitor.
    task automatic step();
        @(posedge CLK_48M);
        #1;
        if (pix_ce) begin
            cur_slot = hphase;
            sub_m    = 3'd0;
            hphase   = hphase + 3'd1;
        end else if (sub_m != 3'd7) begin
            sub_m = sub_m + 3'd1;
        end
        pcnt     = pcnt + 3'd1;
        pix_ce   = (pcnt == 3'd7);
        vid_addr = {6'd0, hphase, 4'd0};
        if (ram_cs)    cs_cnt++;
        if (vid_valid) vv_cnt++;
        if (cpu0_ack) begin
            ack0_cnt++;
            ack0_slot = int'(cur_slot);
            ack0_sub  = int'(sub_m);
            ack0_data = cpu0_rdata;
            if (!stream0) cpu0_req = 1'b0;
        end
        if (cpu1_ack) begin
            ack1_cnt++;
            ack1_slot = int'(cur_slot);
            ack1_sub  = int'(sub_m);
            ack1_data = cpu1_rdata;
            if (!stream1) cpu1_req = 1'b0;
        end
    endtask

    task automatic wait_slot(input logic [2:0] h);
        logic found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            if (sub_m == 3'd0 && cur_slot == h) found = 1'b1;
        end
        if (!found) chk("wait_slot", 32'(cur_slot), 32'(h));
    endtask

    task automatic wait_sub(input logic [2:0] m);
        logic found = 1'b0;
        for (int i = 0; i < 9 && !found; i++) begin
            step();
            if (sub_m == m) found = 1'b1;
        end
        if (!found) chk("wait_sub", 32'(sub_m), 32'(m));
    endtask

    initial begin
        logic [2:0]  s;
        logic [12:0] ea;
        logic        done;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h5A;
        nVRESETH = 1'b0;
        pix_ce = 1'b0; hphase = 3'd0; pcnt = 3'd0;
        nHBLANK = 1'b1; nVBLANK = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        cpu0_req = 0; cpu0_we = 0; cpu0_addr = '0; cpu0_wdata = '0;
        cpu1_req = 0; cpu1_we = 0; cpu1_addr = '0; cpu1_wdata = '0;
        cur_slot = 3'd0; sub_m = 3'd0;
        stream0 = 0; stream1 = 0;
        ack0_cnt = 0; ack1_cnt = 0; vv_cnt = 0; cs_cnt = 0;
        ack0_slot = 0; ack0_sub = 0; ack1_slot = 0; ack1_sub = 0;
        ack0_data = '0; ack1_data = '0;

        // Reset state
        repeat (12) step();
        chk("rst_ctl", {27'd0, vid_valid, cpu0_ack, cpu1_ack, ram_cs, ram_we}, 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_wdata", 32'(ram_wdata), 0);
        chk("rst_rdata", {8'd0, vid_rdata, cpu0_rdata, cpu1_rdata}, 0);

        // Idle for 64 pixels
        nVRESETH = 1'b1;
        cs_cnt = 0; ack0_cnt = 0; ack1_cnt = 0; vv_cnt = 0;
        repeat (512) step();
        chk("idle_cs", cs_cnt, 0);
        chk("idle_acks", ack0_cnt + ack1_cnt + vv_cnt, 0);

        // Video fetch every even slot
        vid_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s = 3'(k);
            wait_slot(s);
            wait_sub(3'd1);
            chk($sformatf("vid_cs%0d", k), 32'(ram_cs), 32'(!s[0]));
            if (!s[0]) chk($sformatf("vid_addr%0d", k), 32'(ram_addr), k * 16);
            wait_sub(3'd6);
            chk($sformatf("vid_valid%0d", k), 32'(vid_valid), 32'(!s[0]));
            if (!s[0]) chk($sformatf("vid_rdata%0d", k), 32'(vid_rdata),
                           32'(8'(k * 16) ^ 8'h5A));
        end

        // Both CPUs read together in slot 0
        wait_slot(3'd0);
        ack0_cnt = 0; ack1_cnt = 0;
        cpu0_req = 1; cpu0_we = 0; cpu0_addr = 13'h100;
        cpu1_req = 1; cpu1_we = 0; cpu1_addr = 13'h200;
        repeat (31) step();
        chk("rd0_cnt", ack0_cnt, 1);
        chk("rd0_slot", ack0_slot, 1);
        chk("rd0_sub", ack0_sub, 6);
        chk("rd0_data", 32'(ack0_data), 32'h5A);
        chk("rd1_cnt", ack1_cnt, 1);
        chk("rd1_slot", ack1_slot, 3);
        chk("rd1_sub", ack1_sub, 6);
        chk("rd1_data", 32'(ack1_data), 32'h5A);

        // CPU1 write takes the unused video slot 2
        vid_req = 1'b0;
        wait_slot(3'd1);
        cpu1_req = 1; cpu1_we = 1; cpu1_addr = 13'h1AA; cpu1_wdata = 8'h5A;
        wait_slot(3'd2);
        for (int m = 0; m < 8; m++) begin
            if (m > 0) step();
            chk($sformatf("wr_cs%0d", m), 32'(ram_cs), 1);
            chk($sformatf("wr_we%0d", m), 32'(ram_we), 32'(m >= 2 && m <= 5));
            chk($sformatf("wr_ack%0d", m), 32'(cpu1_ack), 32'(m == 6));
            if (m == 1) begin
                chk("wr_addr", 32'(ram_addr), 32'h1AA);
                chk("wr_data", 32'(ram_wdata), 32'h5A);
            end
        end
        chk("wr_mem", 32'(mem[13'h1AA]), 32'h5A);

        // Horizontal blank with both CPUs streaming
        vid_req = 1'b1;
        wait_slot(3'd0);
        nHBLANK = 1'b0;
        stream0 = 1; stream1 = 1;
        cpu0_req = 1; cpu0_we = 0; cpu0_addr = 13'h100;
        cpu1_req = 1; cpu1_we = 0; cpu1_addr = 13'h200;
        for (int k = 0; k < 8; k++) begin
            s = 3'(k + 1);
            wait_slot(s);
            if (k == 0) vv_cnt = 0;
            wait_sub(3'd1);
`ifdef VRAM_ARB_BLANK_CPU_EN
            ea = k[0] ? 13'h200 : 13'h100;
`else
            if (!s[0])     ea = {6'd0, s, 4'd0};
            else if (!s[1]) ea = 13'h100;
            else            ea = 13'h200;
`endif
            chk($sformatf("blk_cs%0d", k), 32'(ram_cs), 1);
            chk($sformatf("blk_addr%0d", k), 32'(ram_addr), 32'(ea));
        end
`ifdef VRAM_ARB_BLANK_CPU_EN
        chk("blk_vid", vv_cnt, 0);
`else
        chk("blk_vid", vv_cnt, 3);
`endif
        stream0 = 0; stream1 = 0;
        cpu0_req = 0; cpu1_req = 0;
        nHBLANK = 1'b1;

        // Reset in the middle of a CPU0 write, then retry
        vid_req = 1'b0;
        wait_slot(3'd0);
        cpu0_req = 1; cpu0_we = 1; cpu0_addr = 13'h0F0; cpu0_wdata = 8'hC3;
        wait_slot(3'd1);
        wait_sub(3'd3);
        chk("mid_we", 32'(ram_we), 1);
        chk("mid_cs", 32'(ram_cs), 1);
        ack0_cnt = 0;
        #2;
        nVRESETH = 1'b0;
        #1;
        chk("abort_we", 32'(ram_we), 0);
        chk("abort_cs", 32'(ram_cs), 0);
        repeat (6) step();
        chk("abort_ack", ack0_cnt, 0);
        nVRESETH = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (ack0_cnt != 0) done = 1'b1;
        end
        chk("retry_ack", ack0_cnt, 1);
        chk("retry_sub", ack0_sub, 6);
        chk("retry_mem", 32'(mem[13'h0F0]), 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
